// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and default widths for the immediate extender stage
// Optional skid entry is selected by IMM_EXTEND_SKID_EN in imm_extend_stage.
package imm_ext_pkg;

   typedef enum logic [1:0] {
      IMM_SIGN   = 2'd0,
      IMM_ZERO   = 2'd1,
      IMM_UPPER  = 2'd2,
      IMM_BRANCH = 2'd3
   } imm_mode_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_e;

   localparam int DEF_IN_W  = 16;
   localparam int DEF_OUT_W = 32;
   localparam int DEF_TAG_W = 5;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extension (sign, zero, upper, branch offset)
// Used on the input side of imm_extend_stage; independent of IMM_EXTEND_SKID_EN.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sign_ext;
   logic [OUT_W-1:0] zero_ext;
   logic [OUT_W-1:0] upper_ext;
   logic [OUT_W-1:0] branch_ext;

   assign sign_ext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, imm};
   assign upper_ext  = {imm, {(OUT_W-IN_W){1'b0}}};
   // OUT_W >= IN_W+2 guarantees the two dropped top bits are sign copies
   assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

   always_comb begin
      ext = sign_ext;
      case (imm_mode_e'(mode))
         IMM_SIGN:   ext = sign_ext;
         IMM_ZERO:   ext = zero_ext;
         IMM_UPPER:  ext = upper_ext;
         IMM_BRANCH: ext = branch_ext;
         default:    ext = sign_ext;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered valid/ready immediate extender between decode and execute
// Define IMM_EXTEND_SKID_EN for a two-entry stage with registered in_ready.
module imm_extend_stage
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0] ext;
   logic             accept;
   logic             drain;
   occ_state_e       state;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .ext  (ext)
   );

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

`ifdef IMM_EXTEND_SKID_EN
   logic [OUT_W-1:0] skid_imm;
   logic [TAG_W-1:0] skid_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_imm   <= '0;
         out_tag   <= '0;
         skid_imm  <= '0;
         skid_tag  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  out_imm   <= ext;
                  out_tag   <= in_tag;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  out_imm <= ext;
                  out_tag <= in_tag;
               end else if (accept) begin
                  // consumer stalled after in_ready was already shown high
                  skid_imm <= ext;
                  skid_tag <= in_tag;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (drain) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  out_imm  <= skid_imm;
                  out_tag  <= skid_tag;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_tag   <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  out_imm   <= ext;
                  out_tag   <= in_tag;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept) begin
                  out_imm <= ext;
                  out_tag <= in_tag;
               end else if (drain) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - directed self-checking bench for imm_extend_stage
// Back-pressure and reset expectations follow IMM_EXTEND_SKID_EN.
module tb_imm_extend_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;

   int n_checks = 0;
   int n_errors = 0;

   imm_extend_stage #(
      .IN_W  (16),
      .OUT_W (32),
      .TAG_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] i, input logic [4:0] t);
      in_valid = v;
      in_mode  = m;
      in_imm   = i;
      in_tag   = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [31:0] e_imm, input logic [4:0] e_tag);
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_imm"}, out_imm, e_imm);
      chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, e_tag});
   endtask

   logic [1:0]  s_mode [8];
   logic [15:0] s_imm  [8];
   logic [31:0] s_exp  [8];

   initial begin
      s_mode[0] = 2'd0; s_imm[0] = 16'h0000; s_exp[0] = 32'h00000000;
      s_mode[1] = 2'd1; s_imm[1] = 16'hFFFF; s_exp[1] = 32'h0000FFFF;
      s_mode[2] = 2'd2; s_imm[2] = 16'hFFFF; s_exp[2] = 32'hFFFF0000;
      s_mode[3] = 2'd3; s_imm[3] = 16'h8000; s_exp[3] = 32'hFFFE0000;
      s_mode[4] = 2'd0; s_imm[4] = 16'hFFFF; s_exp[4] = 32'hFFFFFFFF;
      s_mode[5] = 2'd3; s_imm[5] = 16'h7FFF; s_exp[5] = 32'h0001FFFC;
      s_mode[6] = 2'd2; s_imm[6] = 16'h0001; s_exp[6] = 32'h00010000;
      s_mode[7] = 2'd1; s_imm[7] = 16'h1234; s_exp[7] = 32'h00001234;

      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 2'd0, 16'h0000, 5'd0);
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
      rst_n = 1'b1;

      // single-mode vectors, each output drains on the following edge
      drive(1'b1, 2'd0, 16'h8004, 5'd3);  tick(); expect_out("sign_neg", 32'hFFFF8004, 5'd3);
      drive(1'b1, 2'd0, 16'h7FFF, 5'd4);  tick(); expect_out("sign_pos", 32'h00007FFF, 5'd4);
      drive(1'b1, 2'd1, 16'h8004, 5'd5);  tick(); expect_out("zero", 32'h00008004, 5'd5);
      drive(1'b1, 2'd2, 16'h1234, 5'd6);  tick(); expect_out("upper", 32'h12340000, 5'd6);
      drive(1'b1, 2'd3, 16'hFFFF, 5'd7);  tick(); expect_out("branch_neg", 32'hFFFFFFFC, 5'd7);
      drive(1'b1, 2'd3, 16'h0001, 5'd31); tick(); expect_out("branch_pos", 32'h00000004, 5'd31);
      drive(1'b0, 2'd0, 16'h0000, 5'd0);  tick();
      chk("drain_empty", {31'd0, out_valid}, 32'd0);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

      // back-pressure: A, B, C offered while consumer stalls
      out_ready = 1'b0;
      drive(1'b1, 2'd1, 16'h000A, 5'd10); tick();
      expect_out("bp_a", 32'h0000000A, 5'd10);
`ifdef IMM_EXTEND_SKID_EN
      chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 2'd1, 16'h000B, 5'd11); tick();
      chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      expect_out("bp_full_head", 32'h0000000A, 5'd10);
      drive(1'b1, 2'd1, 16'h000C, 5'd12); tick();
      chk("bp_c_held_ready", {31'd0, in_ready}, 32'd0);
      expect_out("bp_c_held_head", 32'h0000000A, 5'd10);
      out_ready = 1'b1;
      tick();
      expect_out("bp_out_b", 32'h0000000B, 5'd11);
      chk("bp_reopen_ready", {31'd0, in_ready}, 32'd1);
      tick();
      expect_out("bp_out_c", 32'h0000000C, 5'd12);
`else
      chk("bp_a_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 2'd1, 16'h000B, 5'd11); tick();
      chk("bp_b_held_ready", {31'd0, in_ready}, 32'd0);
      expect_out("bp_b_held_head", 32'h0000000A, 5'd10);
      out_ready = 1'b1;
      #1;
      chk("bp_comb_ready", {31'd0, in_ready}, 32'd1);
      tick();
      expect_out("bp_out_b", 32'h0000000B, 5'd11);
      drive(1'b1, 2'd1, 16'h000C, 5'd12); tick();
      expect_out("bp_out_c", 32'h0000000C, 5'd12);
`endif
      drive(1'b0, 2'd0, 16'h0000, 5'd0); tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // back-to-back mixed-mode stream at full throughput
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, s_mode[k], s_imm[k], 5'(k + 8));
         tick();
         expect_out($sformatf("stream%0d", k), s_exp[k], 5'(k + 8));
      end
      drive(1'b0, 2'd0, 16'h0000, 5'd0); tick();
      chk("stream_empty", {31'd0, out_valid}, 32'd0);

      // asynchronous reset while holding results
      out_ready = 1'b0;
      drive(1'b1, 2'd0, 16'h1111, 5'd1); tick();
      drive(1'b1, 2'd0, 16'h2222, 5'd2); tick();
      drive(1'b0, 2'd0, 16'h0000, 5'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_imm", out_imm, 32'd0);
      chk("arst_out_tag", {27'd0, out_tag}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 2'd2, 16'hABCD, 5'd9); tick();
      expect_out("post_rst_first", 32'hABCD0000, 5'd9);
      drive(1'b0, 2'd0, 16'h0000, 5'd0); tick();
      chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Parametrised, pipelined immediate extender for the MIPS datapath: takes an IN_W-bit instruction immediate and a mode, and produces an OUT_W-bit operand. Supported modes are sign-extend, zero-extend, upper-load (LUI) and branch-offset (sign-extend then shift left 2). It sits between decode and execute as a registered valid/ready stage. It carries an opaque tag (e.g. destination register) alongside the data, so it can absorb back-pressure without losing operands.

## Interface
- IN_W, 16, immediate input width; must be ≥ 2.
- OUT_W, 32, extended output width; must be ≥ IN_W + 2.
- TAG_W, 5, width of the sideband tag passed through unchanged; must be ≥ 1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a valid immediate.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready at the clk edge.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  imm_mode_e: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  out_imm/out_tag hold a valid result.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_imm  out  OUT_W  extended immediate.
- out_tag  out  TAG_W  tag of the result on out_imm.

## Operation
- SIGN: bits [OUT_W-1:IN_W] are copies of in_imm[IN_W-1]; the low IN_W bits equal in_imm.
- ZERO: the upper bits are 0; the low IN_W bits equal in_imm.
- UPPER: in_imm is placed at [OUT_W-1:OUT_W-IN_W]; all lower bits are 0.
- BRANCH: the SIGN result shifted left by 2 and truncated to OUT_W. Bits [1:0] are 0. Because of the OUT_W ≥ IN_W+2 constraint, no significant bit is lost.
- The extension is computed at accept time. The stored result is never recomputed.
- Results leave in acceptance order (FIFO). There is no drop and no duplication.
- Storage has two entries: a main register that drives the outputs directly, and a skid register.
- Occupancy states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept with no drain → FULL; drain with no accept → EMPTY; accept and drain in the same cycle → ONE, with the new result loaded into main.
  - FULL: drain → ONE, skid moves to main. No accept is possible in FULL.
- in_valid is ignored while in_ready=0. in_imm, in_mode and in_tag are don't-care when no transfer occurs.
- Reset, asynchronous at any time including mid-transfer: both entries are discarded. State becomes EMPTY, out_valid=0, in_ready=1, out_imm=0, out_tag=0. After rst_n deasserts, the first accept is possible at the next clk edge.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on out_imm with out_valid=1 after edge N.
- Throughput is 1 result per cycle while out_ready=1.
- With the skid buffer (see Configuration), in_ready is a register output. There is no combinational path from out_ready to in_ready, and none from inputs to outputs.
- The producer may see in_ready=1 for one cycle after the consumer stalls. The skid entry absorbs that transfer.

## Configuration
- Macro: IMM_EXTEND_SKID_EN.
- Defined:
  - Two-entry behaviour exactly as described above.
  - in_ready is registered: in_ready = (state != FULL).
- Undefined:
  - Only the main register exists; states are EMPTY and ONE.
  - in_ready = !out_valid || out_ready, which is combinational from out_ready.
  - Latency, ordering, reset values and mode arithmetic are identical.
  - Full throughput is kept; only the registered-ready property is lost.

## Structure
- Package imm_ext_pkg holds:
  - the imm_mode_e enum (2 bits: IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH);
  - the occupancy state enum occ_state_e (EMPTY, ONE, FULL);
  - the default width localparams.
- Sub-module imm_ext_core is purely combinational, parametrised by IN_W and OUT_W, and maps (imm, mode) to the extended value. It is instantiated once, on the input side.
- imm_extend_stage holds the occupancy state machine, the main and skid registers, and the handshake logic.

## Test plan
- SIGN, in_imm=16'h8004, tag 5'd3 → one cycle later out_imm=32'hFFFF8004, out_tag=5'd3. With in_imm=16'h7FFF → 32'h00007FFF.
- ZERO, 16'h8004 → 32'h00008004. UPPER, 16'h1234 → 32'h12340000.
- BRANCH, 16'hFFFF → 32'hFFFFFFFC. BRANCH, 16'h0001 → 32'h00000004.
- Back-pressure with out_ready=0, offering A, B, C on consecutive cycles:
  - With skid: A and B are accepted, and in_ready=0 while C is held.
  - Raising out_ready yields A, B, C in order, one per cycle, with no gaps.
  - Without skid: only A is accepted until out_ready rises.
- Back-to-back stream of 8 mixed-mode inputs with out_ready=1 → 8 outputs on 8 consecutive cycles, each matching the reference model.
- Assert rst_n=0 while FULL, asynchronously between edges:
  - out_valid=0, in_ready=1, out_imm=0 and out_tag=0 immediately.
  - After release, the next accepted input is the first output.
